// File: rtl/sram_responder_if.sv
// CPU-side SRAM bus bundle: instruction-fetch port and data port.
// The master modport is the core side; the slave modport is the SRAM responder.
interface sram_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_responder.sv
// Dual-port word-organised SRAM responder with a post-reset clear sweep and one-cycle read latency.
// Optional macro SRAM_RANGE_CHECK_EN adds out-of-range detection and the range_err output.
module sram_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_responder_if.slave      bus,
    output logic                 init_done
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic                 range_err
`endif
);
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_r;
    state_e            nextState_s;
    logic [ADDR_W-1:0] clearCnt_r;
    logic              initDone_r;
    logic [31:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] instIdx_s;
    logic [ADDR_W-1:0] dataIdx_s;
    logic              instRd_s;
    logic              dataAcc_s;
    logic              dataWr_s;
    logic [31:0]       instRdMux_s;
    logic [31:0]       dataRdMux_s;
    logic [31:0]       instRdata_r;
    logic [31:0]       dataRdata_r;
    logic              unusedOk_s;

    // Upper address bits alias onto the array unless range checking drops them.
    assign instIdx_s = bus.inst_sram_addr[ADDR_W+1:2];
    assign dataIdx_s = bus.data_sram_addr[ADDR_W+1:2];
    assign instRd_s  = (state_r == READY) && bus.inst_sram_en;
    assign dataAcc_s = (state_r == READY) && bus.data_sram_en;

`ifdef SRAM_RANGE_CHECK_EN
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;
    logic instInRange_s;
    logic dataInRange_s;
    logic rangeErr_r;

    assign instInRange_s = (bus.inst_sram_addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign dataInRange_s = (bus.data_sram_addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign dataWr_s      = dataAcc_s && dataInRange_s && (bus.data_sram_wen != 4'b0000);
    assign instRdMux_s   = instInRange_s ? mem_r[instIdx_s] : OOR_DATA;
    assign dataRdMux_s   = dataInRange_s ? mem_r[dataIdx_s] : OOR_DATA;
    assign range_err     = rangeErr_r;

    // Sticky flag for any enabled out-of-range access once the array is ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rangeErr_r <= 1'b0;
        end else if ((instRd_s && !instInRange_s) || (dataAcc_s && !dataInRange_s)) begin
            rangeErr_r <= 1'b1;
        end
    end
`else
    assign dataWr_s    = dataAcc_s && (bus.data_sram_wen != 4'b0000);
    assign instRdMux_s = mem_r[instIdx_s];
    assign dataRdMux_s = mem_r[dataIdx_s];
`endif

    // The instruction port is read-only; its write inputs and the byte offset bits are don't-cares.
    assign unusedOk_s = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                          bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0],
                          bus.inst_sram_addr[31:ADDR_W+2], bus.data_sram_addr[31:ADDR_W+2]};

    // Next-state logic: sweep until the last word is written, then stay ready until reset.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clearCnt_r == LAST_IDX) begin
                    nextState_s = READY;
                end else begin
                    nextState_s = CLEAR;
                end
            end
            READY:   nextState_s = READY;
            default: nextState_s = CLEAR;
        endcase
    end

    // State register, clear counter and init_done, which rises on the edge entering READY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= CLEAR;
            clearCnt_r <= {ADDR_W{1'b0}};
            initDone_r <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            initDone_r <= (nextState_s == READY);
            if (state_r == CLEAR) begin
                clearCnt_r <= clearCnt_r + 1'b1;
            end
        end
    end

    // Array storage: the sweep owns the write port while clearing, then the data port takes it.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[clearCnt_r] <= INIT_VAL;
        end else if (dataWr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem_r[dataIdx_s][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read data; sampling the array before the write lands gives read-first on both ports.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instRdata_r <= 32'h0000_0000;
            dataRdata_r <= 32'h0000_0000;
        end else begin
            if (instRd_s) begin
                instRdata_r <= instRdMux_s;
            end
            if (dataAcc_s) begin
                dataRdata_r <= dataRdMux_s;
            end
        end
    end

    assign bus.inst_sram_rdata = instRdata_r;
    assign bus.data_sram_rdata = dataRdata_r;
    assign init_done           = initDone_r;
endmodule
